collision_unit: RTL
===================

COLLISION_UNIT -- requirements
Module: collision_unit

Interface
REQ-001 SIZE, 16, entity bounding-box edge in pixels.
REQ-002 SCREEN_W, 640, playfield width in pixels; SCREEN_H, 480, playfield height in pixels.
REQ-003 CLOCK_50  in  1  single clock; all state changes on its rising edge.
REQ-004 RESET_H  in  1  reset, asynchronous and active-high.
REQ-005 RUN_COLLISION  in  1  request from position controller; held high until COLLISION_DONE seen.
REQ-006 CUR_ADDRESS  in  2  entity-file address of entity under test.
REQ-007 STOP_ADDRESS  in  3  number of valid entity-file entries (0..4).
REQ-008 PROJ_X, PROJ_Y  in  10 each  projected position from position buffer.
REQ-009 EF_ID  in  2  entity-file ID at EF_ADDR: 00 player, 01 enemy, 10 goal, 11 wall.
REQ-010 EF_X, EF_Y  in  10 each  entity-file position at EF_ADDR.
REQ-011 EF_ADDR  out  2  entity-file read address.
REQ-012 COLLISION_DONE  out  1  one-cycle completion pulse.
REQ-013 OUT_X, OUT_Y  out  10 each  resolved position, captured by buffer after DONE.
REQ-014 GAME_OVER_FLAG, YOU_WIN_FLAG  out  1 each  one-cycle event pulses, coincident with COLLISION_DONE.

Function
REQ-015 Entity-file read latency is one cycle: data for EF_ADDR presented in cycle n is sampled in cycle n+1.
REQ-016 States: IDLE, SELF_ADDR, SELF_DATA, SCAN_ADDR, SCAN_DATA, RESOLVE, DONE, WAIT_LOW.
REQ-017 IDLE -> SELF_ADDR when RUN_COLLISION=1; else stay; EF_ADDR=0 in IDLE.
REQ-018 SELF_ADDR drives EF_ADDR=CUR_ADDRESS; SELF_DATA latches self ID and self X/Y, clears scan index, blocked/hit/win flags.
REQ-019 SCAN_ADDR drives EF_ADDR=scan index; SCAN_DATA evaluates that entry, then index+1; SCAN_DATA -> SCAN_ADDR while index+1 < STOP_ADDRESS, else -> RESOLVE.
REQ-020 SELF_DATA -> RESOLVE directly when STOP_ADDRESS=0; otherwise -> SCAN_ADDR.
REQ-021 Entry at index equal to CUR_ADDRESS is walked (2 cycles) but ignored.
REQ-022 Overlap: |PROJ_X-EF_X| < SIZE and |PROJ_Y-EF_Y| < SIZE, differences computed 11-bit signed, no wrap.
REQ-023 Self player: enemy overlap sets hit; goal overlap sets win; wall overlap sets blocked.
REQ-024 Self enemy: player overlap sets hit; wall or other enemy overlap sets blocked; goal ignored.
REQ-025 Self ID 10/11: no flags set; OUT = projection.
REQ-026 RESOLVE registers OUT_X/OUT_Y = self X/Y if blocked, else PROJ_X/PROJ_Y; then -> DONE.
REQ-027 DONE asserts COLLISION_DONE=1 for exactly one cycle, GAME_OVER_FLAG=hit, YOU_WIN_FLAG=win; both flags may pulse together; -> WAIT_LOW.
REQ-028 WAIT_LOW -> IDLE when RUN_COLLISION=0; a still-high request never restarts a scan.
REQ-029 Latency: RUN_COLLISION sampled in IDLE at cycle 0 gives DONE at cycle 4+2*STOP_ADDRESS (STOP_ADDRESS=4 -> cycle 12).
REQ-030 RUN_COLLISION falling in any state other than DONE/WAIT_LOW aborts to IDLE with no DONE or flag pulse; OUT_X/OUT_Y unchanged.
REQ-031 OUT_X/OUT_Y hold their value from RESOLVE until the next RESOLVE.

Reset
REQ-032 RESET_H=1 forces IDLE immediately: EF_ADDR=0, COLLISION_DONE=0, GAME_OVER_FLAG=0, YOU_WIN_FLAG=0, OUT_X=0, OUT_Y=0, all internal flags and index cleared.
REQ-033 Reset mid-scan discards the scan; no pulse is emitted after release until a new request.

Configuration
REQ-034 COLLISION_BOUNDS_EN defined: PROJ_X > SCREEN_W-SIZE or PROJ_Y > SCREEN_H-SIZE sets blocked in SELF_DATA for any self ID 00/01.
REQ-035 COLLISION_BOUNDS_EN undefined: no boundary check; only entity overlaps set blocked.

Verification
REQ-036 Player at (100,100), PROJ (104,100), STOP=2, entry1 wall at (300,300) -> DONE at cycle 8, OUT=(104,100), no flags.
REQ-037 Player at (100,100), PROJ (104,100), entry1 wall at (115,100) -> OUT=(100,100), no flags.
REQ-038 Player PROJ (200,200), entry2 enemy at (210,195), STOP=3 -> GAME_OVER_FLAG and COLLISION_DONE same cycle, cycle 10.
REQ-039 Player PROJ (400,50), goal at (390,60), enemy at (405,45) -> GAME_OVER_FLAG and YOU_WIN_FLAG both pulse.
REQ-040 With COLLISION_BOUNDS_EN, player at (620,10), PROJ (630,10), STOP=1 -> OUT=(620,10); without the macro -> OUT=(630,10).
REQ-041 RUN_COLLISION dropped at cycle 5, or RESET_H pulsed at cycle 5 -> no COLLISION_DONE; next request completes normally; RUN held high after DONE -> no second DONE.

Source files
------------

// File: rtl/collision_unit.sv
// collision_unit
//   Resolves one projected entity move against the entity file. On a request
//   it reads the entity under test, walks every valid entry (one address cycle
//   plus one data cycle each, skipping itself), accumulates blocked / hit / win
//   flags from bounding-box overlaps, then publishes the resolved position and
//   a one-cycle DONE pulse with the event flags.
//
//   Optional build macro: COLLISION_BOUNDS_EN -- when defined, a player or
//   enemy projected past the playfield edge is treated as blocked.
//
// Ports
//   CLOCK_50        in   clock, all state on rising edge
//   RESET_H         in   asynchronous active-high reset
//   RUN_COLLISION   in   request level, held until COLLISION_DONE seen
//   CUR_ADDRESS     in   entity-file address of the entity under test
//   STOP_ADDRESS    in   number of valid entity-file entries (0..4)
//   PROJ_X/PROJ_Y   in   projected position
//   EF_ID/EF_X/EF_Y in   entity-file read data (one-cycle latency)
//   EF_ADDR         out  entity-file read address
//   COLLISION_DONE  out  one-cycle completion pulse
//   OUT_X/OUT_Y     out  resolved position, valid from DONE onward
//   GAME_OVER_FLAG  out  pulse with DONE: player/enemy contact
//   YOU_WIN_FLAG    out  pulse with DONE: player reached goal
module collision_unit #(
    parameter int SIZE     = 16,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic       CLOCK_50,
    input  logic       RESET_H,
    input  logic       RUN_COLLISION,
    input  logic [1:0] CUR_ADDRESS,
    input  logic [2:0] STOP_ADDRESS,
    input  logic [9:0] PROJ_X,
    input  logic [9:0] PROJ_Y,
    input  logic [1:0] EF_ID,
    input  logic [9:0] EF_X,
    input  logic [9:0] EF_Y,
    output logic [1:0] EF_ADDR,
    output logic       COLLISION_DONE,
    output logic [9:0] OUT_X,
    output logic [9:0] OUT_Y,
    output logic       GAME_OVER_FLAG,
    output logic       YOU_WIN_FLAG
);

`ifdef COLLISION_BOUNDS_EN
    localparam logic BOUNDS_EN = 1'b1;
`else
    localparam logic BOUNDS_EN = 1'b0;
`endif

    localparam logic [10:0] SIZE11 = 11'(SIZE);
    localparam logic [9:0]  MAX_X  = 10'(SCREEN_W - SIZE);
    localparam logic [9:0]  MAX_Y  = 10'(SCREEN_H - SIZE);

    localparam logic [1:0] ID_PLAYER = 2'b00;
    localparam logic [1:0] ID_ENEMY  = 2'b01;
    localparam logic [1:0] ID_GOAL   = 2'b10;
    localparam logic [1:0] ID_WALL   = 2'b11;

    typedef enum logic [2:0] {
        IDLE, SELF_ADDR, SELF_DATA, SCAN_ADDR, SCAN_DATA, RESOLVE, DONE, WAIT_LOW
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] self_id;
    logic [1:0] scan_idx;
    logic [9:0] self_x, self_y;
    logic       blocked, hit, win;

    // Overlap test on 11-bit signed differences so no coordinate pair wraps.
    logic signed [10:0] dx, dy;
    logic        [10:0] adx, ady;
    logic               overlap;
    logic               last_entry;
    logic               out_of_bounds;

    assign dx      = $signed({1'b0, PROJ_X}) - $signed({1'b0, EF_X});
    assign dy      = $signed({1'b0, PROJ_Y}) - $signed({1'b0, EF_Y});
    assign adx     = dx[10] ? 11'(-dx) : 11'(dx);
    assign ady     = dy[10] ? 11'(-dy) : 11'(dy);
    assign overlap = (adx < SIZE11) && (ady < SIZE11);

    assign last_entry    = (({1'b0, scan_idx} + 3'd1) >= STOP_ADDRESS);
    assign out_of_bounds = (PROJ_X > MAX_X) || (PROJ_Y > MAX_Y);

    always_ff @(posedge CLOCK_50 or posedge RESET_H) begin
        if (RESET_H) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        EF_ADDR        = 2'd0;
        COLLISION_DONE = 1'b0;
        GAME_OVER_FLAG = 1'b0;
        YOU_WIN_FLAG   = 1'b0;
        case (state)
            IDLE:      if (RUN_COLLISION) state_nxt = SELF_ADDR;
            SELF_ADDR: begin
                EF_ADDR   = CUR_ADDRESS;
                state_nxt = SELF_DATA;
            end
            SELF_DATA: state_nxt = (STOP_ADDRESS == 3'd0) ? RESOLVE : SCAN_ADDR;
            SCAN_ADDR: begin
                EF_ADDR   = scan_idx;
                state_nxt = SCAN_DATA;
            end
            SCAN_DATA: state_nxt = last_entry ? RESOLVE : SCAN_ADDR;
            RESOLVE:   state_nxt = DONE;
            DONE: begin
                COLLISION_DONE = 1'b1;
                GAME_OVER_FLAG = hit;
                YOU_WIN_FLAG   = win;
                state_nxt      = WAIT_LOW;
            end
            WAIT_LOW:  if (!RUN_COLLISION) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
        // A dropped request abandons the scan anywhere before the result is out.
        if (!RUN_COLLISION && state != DONE && state != WAIT_LOW)
            state_nxt = IDLE;
    end

    always_ff @(posedge CLOCK_50 or posedge RESET_H) begin
        if (RESET_H) begin
            self_id  <= 2'd0;
            self_x   <= 10'd0;
            self_y   <= 10'd0;
            scan_idx <= 2'd0;
            blocked  <= 1'b0;
            hit      <= 1'b0;
            win      <= 1'b0;
            OUT_X    <= 10'd0;
            OUT_Y    <= 10'd0;
        end else begin
            case (state)
                SELF_DATA: begin
                    self_id  <= EF_ID;
                    self_x   <= EF_X;
                    self_y   <= EF_Y;
                    scan_idx <= 2'd0;
                    hit      <= 1'b0;
                    win      <= 1'b0;
                    blocked  <= BOUNDS_EN && out_of_bounds && !EF_ID[1];
                end
                SCAN_DATA: begin
                    if (scan_idx != CUR_ADDRESS && overlap) begin
                        if (self_id == ID_PLAYER) begin
                            if (EF_ID == ID_ENEMY) hit     <= 1'b1;
                            if (EF_ID == ID_GOAL)  win     <= 1'b1;
                            if (EF_ID == ID_WALL)  blocked <= 1'b1;
                        end else if (self_id == ID_ENEMY) begin
                            if (EF_ID == ID_PLAYER) hit <= 1'b1;
                            if (EF_ID == ID_WALL || EF_ID == ID_ENEMY) blocked <= 1'b1;
                        end
                    end
                    scan_idx <= scan_idx + 2'd1;
                end
                RESOLVE: begin
                    // Only commit when the request is still alive; an abort
                    // here must leave the previous result in place.
                    if (RUN_COLLISION) begin
                        OUT_X <= blocked ? self_x : PROJ_X;
                        OUT_Y <= blocked ? self_y : PROJ_Y;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
